// File: rtl/alu2_issue_seq.sv
// Issue sequencer around a 10-in/6-out combinational ALU: buffers tagged operands, holds alu_pi for SETTLE_CYC cycles, captures alu_po.
// Optional capture counter (op_count) enabled by defining ALU2_SEQ_STATS_EN.

module alu2_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_ONE;
      if (pop_i)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

module alu2_issue_seq #(
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int SETTLE_CYC = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [9:0]       alu_pi,
  input  logic [5:0]       alu_po,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU2_SEQ_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [9:0]       alu_pi_q;
  logic [TAG_W-1:0] cur_tag_q;

  logic                  in_full, in_empty, in_push, in_pop;
  logic [TAG_W+9:0]      in_head;
  logic                  out_full, out_empty, out_push, out_pop;
  logic [TAG_W+5:0]      out_head;
  logic                  launch;

  assign in_ready = !in_full && !rst;
  assign in_push  = in_valid && in_ready;

  // Launch only if the result will have a slot; nothing else fills the
  // output FIFO while an op is held, so the capture can never overflow.
  assign launch   = (state_q == IDLE) && !in_empty && (!out_full || out_pop);
  assign in_pop   = launch;
  assign out_push = (state_q == HOLD) && (cnt_q == 4'd0);

  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;
  assign out_data  = out_empty ? 6'd0 : out_head[5:0];
  assign out_tag   = out_empty ? '0 : out_head[TAG_W+5:6];
  assign alu_pi    = alu_pi_q;

  alu2_seq_fifo #(.W(TAG_W+10), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .wdata_i ({in_tag, in_data}),
    .rdata_o (in_head),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  alu2_seq_fifo #(.W(TAG_W+6), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .wdata_i ({cur_tag_q, alu_po}),
    .rdata_o (out_head),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      alu_pi_q  <= 10'd0;
      cur_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (launch) begin
          state_q   <= HOLD;
          alu_pi_q  <= in_head[9:0];
          cur_tag_q <= in_head[TAG_W+9:10];
          cnt_q     <= 4'(SETTLE_CYC - 1);
        end
        HOLD: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU2_SEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_push && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= 16'd0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif
endmodule
